// File: rtl/ascon_pack.sv
// Shared ASCON types, round limits and the round-constant rule.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ascon_pack;

    // Five 64-bit words; index 0 is x0, index 4 is x4.
    typedef logic [4:0][63:0] type_state;

    typedef enum logic {
        FSM_IDLE = 1'b0,
        FSM_RUN  = 1'b1
    } perm_fsm_t;

    localparam logic [3:0] ROUND_FIRST_P12 = 4'd0;
    localparam logic [3:0] ROUND_FIRST_P6  = 4'd6;
    localparam logic [3:0] ROUND_LAST      = 4'd11;

    // c_r = {0xF - r, r}: f0 e1 d2 c3 b4 a5 96 87 78 69 5a 4b for r = 0..11.
    function automatic logic [7:0] round_const(input logic [3:0] r);
        return {4'hF - r, r};
    endfunction

endpackage

// File: rtl/perm_iter_layers.sv
// ASCON round layers: constant addition (pc), 5-bit S-box (ps), linear diffusion (pl).
// Latency: purely combinational, chained pc -> ps -> pl forms one round.
// Backpressure: none; outputs follow inputs.
module pc
    import ascon_pack::*;
(
    input  type_state  state_i,
    input  logic [3:0] round_i,
    output type_state  state_o
);
    // Round constant lands in the low byte of x2 only.
    always_comb begin
        state_o          = state_i;
        state_o[2][7:0]  = state_i[2][7:0] ^ round_const(round_i);
    end
endmodule

module ps
    import ascon_pack::*;
(
    input  type_state state_i,
    output type_state state_o
);
    logic [63:0] a0, a1, a2, a3, a4;
    logic [63:0] t0, t1, t2, t3, t4;
    logic [63:0] b0, b1, b2, b3, b4;

    // Bit-sliced S-box: input mix, chi-like nonlinearity, output mix.
    always_comb begin
        a0 = state_i[0] ^ state_i[4];
        a1 = state_i[1];
        a2 = state_i[2] ^ state_i[1];
        a3 = state_i[3];
        a4 = state_i[4] ^ state_i[3];
        t0 = ~a0 & a1;
        t1 = ~a1 & a2;
        t2 = ~a2 & a3;
        t3 = ~a3 & a4;
        t4 = ~a4 & a0;
        b0 = a0 ^ t1;
        b1 = a1 ^ t2;
        b2 = a2 ^ t3;
        b3 = a3 ^ t4;
        b4 = a4 ^ t0;
        state_o[0] = b0 ^ b4;
        state_o[1] = b1 ^ b0;
        state_o[2] = ~b2;
        state_o[3] = b3 ^ b2;
        state_o[4] = b4;
    end
endmodule

module pl
    import ascon_pack::*;
(
    input  type_state state_i,
    output type_state state_o
);
    function automatic logic [63:0] rotr(input logic [63:0] x, input int n);
        return (x >> n) | (x << (64 - n));
    endfunction

    // Per-word diffusion with the fixed ASCON rotation pairs.
    always_comb begin
        state_o[0] = state_i[0] ^ rotr(state_i[0], 19) ^ rotr(state_i[0], 28);
        state_o[1] = state_i[1] ^ rotr(state_i[1], 61) ^ rotr(state_i[1], 39);
        state_o[2] = state_i[2] ^ rotr(state_i[2], 1)  ^ rotr(state_i[2], 6);
        state_o[3] = state_i[3] ^ rotr(state_i[3], 10) ^ rotr(state_i[3], 17);
        state_o[4] = state_i[4] ^ rotr(state_i[4], 7)  ^ rotr(state_i[4], 41);
    end
endmodule

// File: rtl/perm_iter_round_counter.sv
// Round index counter: loads 0 (p12) or 6 (p6), increments, flags round 11.
// Latency: new value visible one cycle after load_i/inc_i.
// Backpressure: none; saturates at the last round instead of wrapping.
module round_counter
    import ascon_pack::*;
(
    input  logic       clock_i,
    input  logic       resetb_i,
    input  logic       load_i,
    input  logic       load_p6_i,
    input  logic       inc_i,
    output logic [3:0] round_o,
    output logic       last_o
);
    logic [3:0] round_q, round_d;

    // Load has priority; increment stops at the last round so r never exceeds 11.
    always_comb begin
        round_d = round_q;
        if (load_i) begin
            round_d = load_p6_i ? ROUND_FIRST_P6 : ROUND_FIRST_P12;
        end else if (inc_i && (round_q != ROUND_LAST)) begin
            round_d = round_q + 4'd1;
        end
    end

    // Round register with synchronous active-low reset.
    always_ff @(posedge clock_i) begin
        if (!resetb_i) begin
            round_q <= 4'd0;
        end else begin
            round_q <= round_d;
        end
    end

    assign round_o = round_q;
    assign last_o  = (round_q == ROUND_LAST);
endmodule

// File: rtl/perm_iter.sv
// Iterative ASCON permutation: one full round (pc, ps, pl) per clock, p12 or p6.
// Latency: start edge to done_o = 12 cycles (p12) / 6 cycles (p6).
// Backpressure: start_i is ignored while busy_o; no request queuing.
module perm_iter
    import ascon_pack::*;
(
    input  logic       clock_i,
    input  logic       resetb_i,
    input  logic       start_i,
    input  logic       mode_i,
    input  type_state  state_i,
    output type_state  state_o,
    output logic       busy_o,
    output logic       done_o,
    output logic [3:0] round_o
);
    perm_fsm_t  fsm_q, fsm_d;
    type_state  state_q, state_d;
    type_state  pc_out, ps_out, pl_out;
    logic       done_q, done_d;
    logic       cnt_load, cnt_inc, cnt_last;
    logic [3:0] round;

    round_counter u_round_counter (
        .clock_i   (clock_i),
        .resetb_i  (resetb_i),
        .load_i    (cnt_load),
        .load_p6_i (mode_i),
        .inc_i     (cnt_inc),
        .round_o   (round),
        .last_o    (cnt_last)
    );

    pc u_pc (.state_i(state_q), .round_i(round), .state_o(pc_out));
    ps u_ps (.state_i(pc_out),  .state_o(ps_out));
    pl u_pl (.state_i(ps_out),  .state_o(pl_out));

    // Next-state: IDLE loads a new state on start; RUN writes one round back per cycle.
    always_comb begin
        fsm_d    = fsm_q;
        state_d  = state_q;
        done_d   = 1'b0;
        cnt_load = 1'b0;
        cnt_inc  = 1'b0;
        case (fsm_q)
            FSM_IDLE: begin
                if (start_i) begin
                    fsm_d    = FSM_RUN;
                    state_d  = state_i;
                    cnt_load = 1'b1;
                end
            end
            FSM_RUN: begin
                state_d = pl_out;
                if (cnt_last) begin
                    fsm_d  = FSM_IDLE;
                    done_d = 1'b1;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            default: fsm_d = FSM_IDLE;
        endcase
    end

    // FSM, state word and done pulse registers; reset aborts any run without a done pulse.
    always_ff @(posedge clock_i) begin
        if (!resetb_i) begin
            fsm_q   <= FSM_IDLE;
            state_q <= '0;
            done_q  <= 1'b0;
        end else begin
            fsm_q   <= fsm_d;
            state_q <= state_d;
            done_q  <= done_d;
        end
    end

    assign state_o = state_q;
    assign busy_o  = (fsm_q == FSM_RUN);
    assign done_o  = done_q;
    assign round_o = round;
endmodule

// File: tb/tb_perm_iter.sv
// Self-checking bench for perm_iter: vector table plus scoreboard, hand-written corner sequences.
module tb_perm_iter;
    import ascon_pack::*;

    logic       clock_i  = 1'b0;
    logic       resetb_i = 1'b0;
    logic       start_i  = 1'b0;
    logic       mode_i   = 1'b0;
    type_state  state_i  = '0;
    type_state  state_o;
    logic       busy_o;
    logic       done_o;
    logic [3:0] round_o;

    perm_iter dut (
        .clock_i  (clock_i),
        .resetb_i (resetb_i),
        .start_i  (start_i),
        .mode_i   (mode_i),
        .state_i  (state_i),
        .state_o  (state_o),
        .busy_o   (busy_o),
        .done_o   (done_o),
        .round_o  (round_o)
    );

    always #5 clock_i = ~clock_i;

    int cyc    = 0;
    int checks = 0;
    int passes = 0;
    int last_start = 0;

    always @(posedge clock_i) cyc <= cyc + 1;

    // Reference tables written out independently of the RTL formulas.
    localparam logic [4:0] SBOX [32] = '{
        5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
        5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
        5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
        5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17};
    localparam logic [7:0] RC_TB [12] = '{
        8'hf0, 8'he1, 8'hd2, 8'hc3, 8'hb4, 8'ha5,
        8'h96, 8'h87, 8'h78, 8'h69, 8'h5a, 8'h4b};

    function automatic logic [63:0] ror(input logic [63:0] x, input int n);
        logic [63:0] y;
        for (int i = 0; i < 64; i++) y[i] = x[(i + n) % 64];
        return y;
    endfunction

    function automatic type_state model_round(input type_state s, input int r);
        type_state  a, b;
        logic [4:0] v, o;
        a = s;
        a[2][7:0] = a[2][7:0] ^ RC_TB[r];
        for (int i = 0; i < 64; i++) begin
            v = {a[0][i], a[1][i], a[2][i], a[3][i], a[4][i]};
            o = SBOX[v];
            b[0][i] = o[4]; b[1][i] = o[3]; b[2][i] = o[2]; b[3][i] = o[1]; b[4][i] = o[0];
        end
        a[0] = b[0] ^ ror(b[0], 19) ^ ror(b[0], 28);
        a[1] = b[1] ^ ror(b[1], 61) ^ ror(b[1], 39);
        a[2] = b[2] ^ ror(b[2], 1)  ^ ror(b[2], 6);
        a[3] = b[3] ^ ror(b[3], 10) ^ ror(b[3], 17);
        a[4] = b[4] ^ ror(b[4], 7)  ^ ror(b[4], 41);
        return a;
    endfunction

    function automatic type_state model_perm(input type_state s, input int first);
        type_state a;
        a = s;
        for (int r = first; r < 12; r++) a = model_round(a, r);
        return a;
    endfunction

    function automatic type_state mk(input logic [63:0] x0, x1, x2, x3, x4);
        type_state s;
        s[0] = x0; s[1] = x1; s[2] = x2; s[3] = x3; s[4] = x4;
        return s;
    endfunction

    task automatic check_bits(input string name, input logic [319:0] act, input logic [319:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    typedef struct {
        type_state exp;
        int        start_cyc;
        int        first;
        int        lat;
    } sb_t;
    sb_t sb_q[$];

    typedef struct {
        logic      mode;
        type_state st;
        int        first;
        int        lat;
    } vec_t;
    vec_t vec [5];

    // Scoreboard: per-cycle round index while running, result/latency on done.
    always @(negedge clock_i) begin : monitor
        sb_t e;
        if (resetb_i && busy_o && sb_q.size() > 0)
            check_bits("round_step", round_o, sb_q[0].first + (cyc - sb_q[0].start_cyc));
        if (done_o) begin
            if (sb_q.size() == 0) begin
                check_bits("done_unexpected", done_o, 1'b0);
            end else begin
                e = sb_q.pop_front();
                check_bits("latency", cyc - e.start_cyc, e.lat);
                check_bits("final_state", state_o, e.exp);
                check_bits("busy_at_done", busy_o, 1'b0);
                check_bits("round_at_done", round_o, 4'd11);
            end
        end
    end

    task automatic tick();
        @(posedge clock_i);
        #1;
    endtask

    task automatic start_run(input logic m, input type_state s, input logic push);
        sb_t e;
        mode_i  = m;
        state_i = s;
        start_i = 1'b1;
        if (push) begin
            e.first     = m ? 6 : 0;
            e.lat       = m ? 6 : 12;
            e.exp       = model_perm(s, e.first);
            e.start_cyc = cyc + 1;
            last_start  = e.start_cyc;
            sb_q.push_back(e);
        end
        tick();
        start_i = 1'b0;
        mode_i  = 1'b0;
        state_i = '0;
    endtask

    task automatic wait_done(input int budget);
        for (int n = 0; n < budget && !done_o; n++) tick();
        check_bits("done_within_budget", done_o, 1'b1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_bits({tag, "_state"}, state_o, '0);
        check_bits({tag, "_busy"},  busy_o,  1'b0);
        check_bits({tag, "_done"},  done_o,  1'b0);
        check_bits({tag, "_round"}, round_o, 4'd0);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : main
        type_state golden, other, exp;
        int        start_a, done_seen, n;

        golden = mk(64'h80400c0600000000, 64'h0001020304050607, 64'h08090a0b0c0d0e0f,
                    64'h0001020304050607, 64'h08090a0b0c0d0e0f);
        other  = mk(64'hdeadbeefcafef00d, 64'h0123456789abcdef, 64'hfedcba9876543210,
                    64'h5555aaaa5555aaaa, 64'h0f0f0f0ff0f0f0f0);

        vec[0] = '{mode: 1'b0, st: golden, first: 0, lat: 12};
        vec[1] = '{mode: 1'b1, st: golden, first: 6, lat: 6};
        vec[2] = '{mode: 1'b0, st: '0,     first: 0, lat: 12};
        vec[3] = '{mode: 1'b1, st: '1,     first: 6, lat: 6};
        vec[4] = '{mode: 1'b0, st: other,  first: 0, lat: 12};

        // Reset held two cycles.
        resetb_i = 1'b0;
        repeat (2) tick();
        check_reset_outputs("reset");
        resetb_i = 1'b1;
        tick();

        // Table: start, check first cycle, let the scoreboard judge the result, then check hold.
        for (int i = 0; i < 5; i++) begin
            start_run(vec[i].mode, vec[i].st, 1'b1);
            check_bits("busy_after_start", busy_o, 1'b1);
            check_bits("round_first", round_o, vec[i].first);
            exp = model_perm(vec[i].st, vec[i].first);
            wait_done(20);
            tick();
            check_bits("done_one_cycle", done_o, 1'b0);
            check_bits("state_hold", state_o, exp);
            check_bits("round_hold", round_o, 4'd11);
        end

        // p6: x2 low byte at the constant-addition output in round 6.
        start_run(1'b1, golden, 1'b1);
        check_bits("p6_pc_x2_byte", dut.pc_out[2][7:0], 8'h99);
        wait_done(20);
        tick();

        // Constant trace on an all-zero state.
        start_run(1'b0, '0, 1'b1);
        for (int k = 0; k < 12; k++) begin
            check_bits("rc_trace", dut.pc_out[2][7:0] ^ state_o[2][7:0], RC_TB[k]);
            tick();
        end
        wait_done(4);
        tick();

        // start while busy: ignored, result unchanged.
        start_run(1'b0, golden, 1'b1);
        tick();
        start_run(1'b1, other, 1'b0);
        check_bits("overlap_busy", busy_o, 1'b1);
        wait_done(20);
        tick();

        // start in the done cycle: accepted with no idle gap, 13-cycle p12 throughput.
        start_run(1'b0, other, 1'b1);
        start_a = last_start;
        wait_done(20);
        start_run(1'b1, golden, 1'b1);
        check_bits("b2b_no_gap", busy_o, 1'b1);
        check_bits("b2b_done_fell", done_o, 1'b0);
        check_bits("b2b_throughput", last_start - start_a, 13);
        wait_done(20);
        tick();

        // Reset and start in the same cycle: reset wins.
        resetb_i = 1'b0;
        start_i  = 1'b1;
        state_i  = golden;
        tick();
        start_i  = 1'b0;
        state_i  = '0;
        resetb_i = 1'b1;
        check_reset_outputs("reset_vs_start");
        tick();

        // Reset mid-run at round 5: abort with no done pulse, then a clean p12 run.
        start_run(1'b0, golden, 1'b1);
        for (n = 0; n < 20 && round_o != 4'd5; n++) tick();
        check_bits("reached_round5", round_o, 4'd5);
        resetb_i = 1'b0;
        sb_q.delete();
        tick();
        check_reset_outputs("midrun_reset");
        resetb_i = 1'b1;
        done_seen = 0;
        for (int k = 0; k < 14; k++) begin
            tick();
            if (done_o) done_seen++;
        end
        check_bits("no_done_after_abort", done_seen, 0);
        start_run(1'b0, golden, 1'b1);
        wait_done(20);
        tick();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
